// File: rtl/reorder_buffer_if.sv
// Shared payload types and the rename/writeback/commit bundle of the reorder buffer.
// The package rides in this file so both the interface and the design see the same types.
package reorder_buffer_pkg;
    localparam int unsigned PIDX_W = 6;

    typedef struct packed {
        logic              valid;
        logic [PIDX_W-1:0] idx;
    } p_reg_t;

    typedef struct packed {
        logic   valid;
        p_reg_t rd;
    } rinstr_t;
endpackage

interface reorder_buffer_if #(
    parameter int unsigned CW = 5
);
    import reorder_buffer_pkg::*;

    rinstr_t         rinstr_i;
    p_reg_t          wb_i;
    logic            flush_i;
    p_reg_t          p_commit_o;
    logic            rob_full_o;
    logic            rob_empty_o;
    logic [CW-1:0]   count_o;

    modport master (
        output rinstr_i, wb_i, flush_i,
        input  p_commit_o, rob_full_o, rob_empty_o, count_o
    );

    modport slave (
        input  rinstr_i, wb_i, flush_i,
        output p_commit_o, rob_full_o, rob_empty_o, count_o
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates renamed instructions at the tail, marks them
// done on writeback and retires one completed entry per cycle from the head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    reorder_buffer_if.slave  rob
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  has_dst_q, has_dst_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [PIDX_W-1:0] pidx_q [DEPTH];
    logic [PIDX_W-1:0] pidx_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    p_reg_t            commit_q, commit_d;

    logic full;
    logic push;
    logic pop;
    logic wb_fire;
    logic alloc_dst;

    // Flags depend only on the registered count, never on this cycle's request.
    assign full            = (count_q == CW'(DEPTH));
    assign rob.rob_full_o  = full;
    assign rob.rob_empty_o = (count_q == '0);
    assign rob.count_o     = count_q;
    assign rob.p_commit_o  = commit_q;

    // Next-state: writeback marking, head retirement, tail allocation, flush override.
    always_comb begin
        valid_d   = valid_q;
        has_dst_d = has_dst_q;
        done_d    = done_q;
        pidx_d    = pidx_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        commit_d  = '0;

        push      = rob.rinstr_i.valid && !full;
        pop       = valid_q[head_q] && done_q[head_q];
        wb_fire   = rob.wb_i.valid && (rob.wb_i.idx != '0);
        alloc_dst = rob.rinstr_i.rd.valid && (rob.rinstr_i.rd.idx != '0);

        // Only entries valid before the edge can match, so a same-cycle allocation never does.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_fire && valid_q[i] && has_dst_q[i] && !done_q[i]
                && (pidx_q[i] == rob.wb_i.idx)) begin
                done_d[i] = 1'b1;
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
            commit_d.valid  = has_dst_q[head_q];
            commit_d.idx    = has_dst_q[head_q] ? pidx_q[head_q] : '0;
        end

        if (push) begin
            valid_d[tail_q]   = 1'b1;
            has_dst_d[tail_q] = alloc_dst;
            pidx_d[tail_q]    = rob.rinstr_i.rd.idx;
            done_d[tail_q]    = !alloc_dst;
            tail_d            = tail_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (rob.flush_i) begin
            valid_d  = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            commit_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q   <= '0;
            has_dst_q <= '0;
            done_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pidx_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            commit_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            has_dst_q <= has_dst_d;
            done_q    <= done_d;
            pidx_q    <= pidx_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            commit_q  <= commit_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, in-order commit, no-destination retire,
// full/drop/wrap, push-pop at full, flush and mid-operation reset.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic clk = 1'b0;
    logic rst_i;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reorder_buffer_if #(.CW(CW)) rob_if ();

    reorder_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .rob   (rob_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_commit(input string tag, input logic v, input logic [5:0] idx);
        chk(tag, 32'({rob_if.p_commit_o.valid, rob_if.p_commit_o.idx}), 32'({v, idx}));
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic full, input logic empty);
        chk({tag, "_count"}, 32'(rob_if.count_o), 32'(cnt));
        chk({tag, "_full"},  32'(rob_if.rob_full_o), 32'(full));
        chk({tag, "_empty"}, 32'(rob_if.rob_empty_o), 32'(empty));
    endtask

    // One clock: inputs held across the edge, then returned to idle 1 ns after it.
    task automatic cyc(input logic av, input logic rv, input logic [5:0] ri,
                       input logic wv, input logic [5:0] wi, input logic fl);
        rob_if.rinstr_i.valid    = av;
        rob_if.rinstr_i.rd.valid = rv;
        rob_if.rinstr_i.rd.idx   = ri;
        rob_if.wb_i.valid        = wv;
        rob_if.wb_i.idx          = wi;
        rob_if.flush_i           = fl;
        @(posedge clk);
        #1;
        rob_if.rinstr_i = '0;
        rob_if.wb_i     = '0;
        rob_if.flush_i  = 1'b0;
    endtask

    task automatic alloc(input logic rv, input logic [5:0] idx);
        cyc(1'b1, rv, idx, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic wb(input logic [5:0] idx);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, idx, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        rob_if.rinstr_i = '0;
        rob_if.wb_i     = '0;
        rob_if.flush_i  = 1'b0;

        // Reset held for two cycles
        rst_i = 1'b1;
        idle();
        idle();
        rst_i = 1'b0;
        chk_state("reset", 0, 1'b0, 1'b1);
        chk_commit("reset_commit", 1'b0, 6'd0);

        // In-order commit: wb 33 at t, wb 32 at t+2, commits at t+4 and t+5
        alloc(1'b1, 6'd32);
        chk_state("alloc1", 1, 1'b0, 1'b0);
        alloc(1'b1, 6'd33);
        chk_state("alloc2", 2, 1'b0, 1'b0);
        wb(6'd33);
        chk_commit("ooo_hold_t1", 1'b0, 6'd0);
        idle();
        chk_commit("ooo_hold_t2", 1'b0, 6'd0);
        wb(6'd32);
        chk_commit("ooo_hold_t3", 1'b0, 6'd0);
        idle();
        chk_commit("commit32", 1'b1, 6'd32);
        chk_state("after32", 1, 1'b0, 1'b0);
        idle();
        chk_commit("commit33", 1'b1, 6'd33);
        chk_state("after33", 0, 1'b0, 1'b1);
        idle();
        chk_commit("quiet_after_33", 1'b0, 6'd0);

        // x0 destination and no-destination entries retire on their own
        alloc(1'b1, 6'd0);
        alloc(1'b0, 6'd5);
        chk_commit("x0_retire", 1'b0, 6'd0);
        chk_state("x0_mid", 1, 1'b0, 1'b0);
        idle();
        chk_commit("nodst_retire", 1'b0, 6'd0);
        chk_state("nodst_done", 0, 1'b0, 1'b1);

        // Fill to 16, 17th request dropped
        for (int k = 0; k < 16; k++) begin
            alloc(1'b1, 6'(32 + k));
        end
        chk_state("full", 16, 1'b1, 1'b0);
        alloc(1'b1, 6'd50);
        chk_state("drop17", 16, 1'b1, 1'b0);
        chk_commit("drop17_commit", 1'b0, 6'd0);

        // Push at full with head done: pop happens, push dropped, then accepted
        wb(6'd32);
        chk_state("head_done", 16, 1'b1, 1'b0);
        alloc(1'b1, 6'd48);
        chk_commit("pushpop_commit", 1'b1, 6'd32);
        chk_state("pushpop", 15, 1'b0, 1'b0);
        alloc(1'b1, 6'd48);
        chk_state("refill", 16, 1'b1, 1'b0);
        chk_commit("refill_commit", 1'b0, 6'd0);

        // Reverse-order writebacks, then in-order drain across the pointer wrap
        for (int k = 0; k < 16; k++) begin
            wb(6'(48 - k));
            chk_commit("rev_wb_hold", 1'b0, 6'd0);
        end
        for (int k = 0; k < 16; k++) begin
            idle();
            chk_commit("drain_order", 1'b1, 6'(33 + k));
        end
        chk_state("drained", 0, 1'b0, 1'b1);
        idle();
        chk_commit("drained_quiet", 1'b0, 6'd0);

        // Flush with 5 in flight, 2 done, alongside a writeback and an allocation
        alloc(1'b1, 6'd60);
        alloc(1'b1, 6'd61);
        alloc(1'b0, 6'd0);
        alloc(1'b1, 6'd63);
        alloc(1'b1, 6'd50);
        wb(6'd61);
        chk_state("pre_flush", 5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 6'd7, 1'b1, 6'd60, 1'b1);
        chk_state("flush", 0, 1'b0, 1'b1);
        chk_commit("flush_commit", 1'b0, 6'd0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk_commit("post_flush_quiet", 1'b0, 6'd0);
            chk("post_flush_count", 32'(rob_if.count_o), 32'd0);
        end

        // Operation resumes from a clean head after flush
        alloc(1'b1, 6'd40);
        wb(6'd40);
        chk_commit("post_flush_hold", 1'b0, 6'd0);
        idle();
        chk_commit("post_flush_commit", 1'b1, 6'd40);
        chk_state("post_flush_empty", 0, 1'b0, 1'b1);

        // Reset mid-operation suppresses the pending commit
        alloc(1'b1, 6'd20);
        wb(6'd20);
        rst_i = 1'b1;
        idle();
        rst_i = 1'b0;
        chk_commit("midrst_commit", 1'b0, 6'd0);
        chk_state("midrst", 0, 1'b0, 1'b1);
        idle();
        chk_commit("midrst_quiet", 1'b0, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer that sits directly downstream of the rename stage. It captures each valid renamed instruction (`rinstr_t`) in program order and marks entries complete on writeback of their physical destination. It retires completed entries from the head, one per cycle, and drives `p_commit` (`p_reg_t`) back to rename so the previous mapping is freed and the busy bit is cleared.

## Interface

**Parameters**
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2.
- `CW`, `$clog2(DEPTH)+1`: width of the occupancy counter.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `rinstr_i` input `rinstr_t`: renamed instruction from rename. Allocation is requested when `rinstr_i.valid` is 1.
- `wb_i` input `p_reg_t`: execution writeback. `valid` plus the 6-bit physical index that has completed.
- `flush_i` input 1: discards all in-flight entries.
- `p_commit_o` output `p_reg_t`: registered in-order commit of a physical destination to rename.
- `rob_full_o` output 1: `count == DEPTH`. Upstream must stall while this is high.
- `rob_empty_o` output 1: `count == 0`.
- `count_o` output `CW`: current occupancy.

## Operation

**Entry state**
- `valid`, `has_dst`, `pidx[5:0]`, `done`.
- Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.

**Allocation**
- Occurs when `rinstr_i.valid && !rob_full_o`. The entry is written at the tail, and the tail pointer increments.
- `has_dst = rinstr_i.rd.valid && rinstr_i.rd.idx != 0`.
- `pidx = rinstr_i.rd.idx`.
- `done = !has_dst`: instructions with no destination, or whose destination is x0, are complete on entry.
- A request while full is dropped silently, with no state change. This holds even if a pop happens in the same cycle, because full is evaluated on the registered count.

**Writeback**
- Condition: `wb_i.valid && wb_i.idx != 0`.
- Sets `done` on every entry that satisfies all of: valid before the edge, `has_dst`, not done, and `pidx == wb_i.idx`. Rename guarantees at most one such entry.
- An entry allocated in the same cycle is not matched by that cycle's writeback.
- A writeback that matches no entry is ignored.

**Commit**
- If the head entry is valid and done, it is popped at the edge: the head pointer increments and the entry's `valid` is cleared.
- `p_commit_o.valid` is registered to `has_dst` of the popped entry, and `p_commit_o.idx` to its `pidx`.
- When nothing is popped, or the popped entry has no destination, `p_commit_o.valid` is 0 and `idx` is 0.
- At most one commit per cycle.

**Counter**
- `count_next = count + push - pop`.
- A push and a pop in the same cycle leave `count` unchanged and advance both pointers.

**Flush**
- `flush_i` takes priority over allocation, writeback, and commit in the same cycle.
- At the edge, all `valid` bits, both pointers, and `count` are cleared, and `p_commit_o` is cleared.
- No commit is emitted for flushed entries.

**Reset (`rst_i` = 1)**
- Same effect as flush.
- All `done`, `has_dst`, and `pidx` fields are cleared.
- Output values in the cycle after reset: `p_commit_o = '0`, `rob_full_o = 0`, `rob_empty_o = 1`, `count_o = 0`.
- Reset asserted mid-operation discards everything, and no commit is produced.

## Timing

- Allocation to visibility: an instruction allocated in cycle t is counted in `count_o` in cycle t+1.
- A no-destination instruction allocated in cycle t that lands at the head is popped at the end of t+1. Its commit slot appears in t+2 with `p_commit_o.valid` = 0.
- Writeback to commit: `wb_i` in cycle t sets `done` at the end of t.
- If that entry is at the head in t+1, it is popped at the end of t+1 and `p_commit_o` is valid during cycle t+2.
- There is no same-cycle bypass from `wb_i` to commit.
- Full and empty flags are combinational functions of the registered `count` only. They have no dependency on `rinstr_i` in the same cycle.
- Sustained throughput: one allocation plus one commit per cycle.
- Out-of-order writebacks are held until all older entries are done.

## Test plan

- **Reset:** hold `rst_i` for 2 cycles. Then `rob_empty_o` = 1, `count_o` = 0, and `p_commit_o.valid` = 0.
- **In-order commit:** allocate `pidx` 32, then 33. Write back 33 in cycle t and 32 in cycle t+2.
  - Expect a commit of 32 in cycle t+4 and of 33 in cycle t+5.
  - No commit occurs before 32 is committed.
- **x0 and no-destination entries:** allocate one entry with rd x0 (`idx` 0) and one with `rd.valid` = 0.
  - Both retire with no writeback.
  - `p_commit_o.valid` stays 0, and `count_o` returns to 0.
- **Full and wrap:** allocate 16 entries with `pidx` 32–47.
  - `rob_full_o` = 1, and a 17th request is dropped with `count_o` staying 16.
  - Write back all 16 and refill. After the pointers wrap, commit order is still correct.
- **Same-cycle push and pop at full:** with the buffer full and the head done, present an allocation.
  - The pop occurs and the push is dropped, so `count_o` = 15.
  - In the next cycle the push is accepted, so `count_o` = 16.
- **Flush:** with 5 entries in flight, 2 of them done, assert `flush_i` together with a `wb_i` and an allocation.
  - Next cycle: `count_o` = 0 and `rob_empty_o` = 1.
  - No `p_commit_o.valid` is produced for the flushed entries.
